// File: rtl/chunked_add_sequencer_pkg.sv
// chunked_add_sequencer_pkg: shared state encoding, slice width and chunk-count helper
package chunked_add_sequencer_pkg;
   localparam int CHUNK_W = 4;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
   function automatic int nchunk(input int width);
      return width / CHUNK_W;
   endfunction
endpackage

// File: rtl/chunked_add_sequencer_if.sv
// chunked_add_sequencer_if: operand/result handshake bundle for the sequenced adder
interface chunked_add_sequencer_if #(parameter int WIDTH = 16);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;
   logic             busy;
   modport master (output in_valid, in_a, in_b, in_cin, out_ready,
                   input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy);
   modport slave  (input  in_valid, in_a, in_b, in_cin, out_ready,
                   output in_ready, out_valid, out_sum, out_cout, out_ovf, busy);
endinterface

// File: rtl/chunked_add_sequencer_adder4_ks.sv
// adder4_ks: combinational 4-bit Kogge-Stone prefix adder slice
module adder4_ks (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);
   logic [3:0] p0, g0, p1, g1, g2;
   // cin is folded into bit 0's generate so every prefix group already includes it
   assign p0   = a ^ b;
   assign g0   = {a[3:1] & b[3:1], (a[0] & b[0]) | (p0[0] & cin)};
   assign g1   = {g0[3:1] | (p0[3:1] & g0[2:0]), g0[0]};
   assign p1   = {p0[3:1] & p0[2:0], p0[0]};
   assign g2   = {g1[3:2] | (p1[3:2] & g1[1:0]), g1[1:0]};
   assign sum  = p0 ^ {g2[2:0], cin};
   assign cout = g2[3];
endmodule

// File: rtl/chunked_add_sequencer.sv
// chunked_add_sequencer: WIDTH-bit adder that reuses one 4-bit slice, LS nibble first
module chunked_add_sequencer
   import chunked_add_sequencer_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input logic                   clk,
   input logic                   rst,
   chunked_add_sequencer_if.slave bus
);
   localparam int             NCHUNK = nchunk(WIDTH);
   localparam int             IW     = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
   localparam logic [1:0]     S_IDLE = IDLE;
   localparam logic [1:0]     S_RUN  = RUN;
   localparam logic [1:0]     S_DONE = DONE;
   localparam logic [IW-1:0]  LAST   = IW'(NCHUNK - 1);

   logic [1:0]         state;
   logic [WIDTH-1:0]   a, b, sum;
   logic               carry;
   logic [IW-1:0]      idx;
   logic [CHUNK_W-1:0] s_sum;
   logic               s_cout;

   adder4_ks slice (
      .a    (a[int'(idx) * CHUNK_W +: CHUNK_W]),
      .b    (b[int'(idx) * CHUNK_W +: CHUNK_W]),
      .cin  (carry),
      .sum  (s_sum),
      .cout (s_cout)
   );

   // accept in IDLE, write one nibble per RUN cycle, hold the result in DONE until taken
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         a     <= '0;
         b     <= '0;
         sum   <= '0;
         carry <= 1'b0;
         idx   <= '0;
      end else if (state == S_IDLE) begin
         if (bus.in_valid) begin
            a     <= bus.in_a;
            b     <= bus.in_b;
            carry <= bus.in_cin;
            sum   <= '0;
            idx   <= '0;
            state <= S_RUN;
         end
      end else if (state == S_RUN) begin
         sum[int'(idx) * CHUNK_W +: CHUNK_W] <= s_sum;
         carry <= s_cout;
         idx   <= idx == LAST ? '0 : idx + 1'b1;
         if (idx == LAST) state <= S_DONE;
      end else if (bus.out_ready) begin
         state <= S_IDLE;
      end
   end

   assign bus.in_ready  = state == S_IDLE;
   assign bus.out_valid = state == S_DONE;
   assign bus.busy      = state != S_IDLE;
   assign bus.out_sum   = sum;
   assign bus.out_cout  = bus.out_valid & carry;
   assign bus.out_ovf   = bus.out_valid & (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: tb/tb_chunked_add_sequencer.sv
// tb_chunked_add_sequencer: scoreboard bench with an arithmetic reference model
module tb_chunked_add_sequencer;
   import chunked_add_sequencer_pkg::*;
   localparam int W = 16;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   errors  = 0;
   int   bp_mode = 0;
   exp_t q[$];

   always #5 clk = ~clk;

   chunked_add_sequencer_if #(.WIDTH(W)) bus ();
   chunked_add_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      exp_t   m;
      longint ua, ub, u, sa, sb, s;
      ua = longint'(a);
      ub = longint'(b);
      u  = ua + ub + longint'(cin);
      sa = a[W-1] ? ua - (longint'(1) << W) : ua;
      sb = b[W-1] ? ub - (longint'(1) << W) : ub;
      s  = sa + sb + longint'(cin);
      m.sum  = u[W-1:0];
      m.cout = u[W];
      m.ovf  = (s >= (longint'(1) << (W - 1))) || (s < -(longint'(1) << (W - 1)));
      return m;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // drives out_ready for the coming edge, then checks any presented result against the scoreboard head
   always @(negedge clk) begin
      bus.out_ready = bp_mode == 0 ? 1'b1 : bp_mode == 1 ? 1'b0 : ($urandom_range(0, 2) != 0);
      if (!rst && bus.out_valid) begin
         if (q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_result: got %h expected no result", bus.out_sum);
         end else begin
            chk("sum", bus.out_sum, q[0].sum);
            chk("cout", W'(bus.out_cout), W'(q[0].cout));
            chk("ovf", W'(bus.out_ovf), W'(q[0].ovf));
            if (bus.out_ready) void'(q.pop_front());
         end
      end
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input bit expect_it);
      int n = 0;
      @(negedge clk);
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_cin   = cin;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         vectors++;
         errors++;
         $display("FAIL issue_timeout: got in_ready=0 expected 1");
         bus.in_valid = 1'b0;
         return;
      end
      if (expect_it) q.push_back(model(a, b, cin));
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || bus.busy) && n < 500) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (q.size() != 0 || bus.busy) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      end
   endtask

   initial begin
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_a     = '0;
      bus.in_b     = '0;
      bus.in_cin   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", W'(bus.in_ready), W'(1));
      chk("rst_out_valid", W'(bus.out_valid), W'(0));
      chk("rst_busy", W'(bus.busy), W'(0));
      chk("rst_sum", bus.out_sum, W'(0));
      rst = 1'b0;

      issue(16'h00FF, 16'h0001, 1'b0, 1'b1);
      repeat (nchunk(W) - 1) begin
         @(posedge clk);
         #1 chk("lat_low", W'(bus.out_valid), W'(0));
      end
      @(posedge clk);
      #1 chk("lat_high", W'(bus.out_valid), W'(1));
      @(posedge clk);
      #1 chk("one_cycle_valid", W'(bus.out_valid), W'(0));

      issue(16'hFFFF, 16'h0000, 1'b1, 1'b1);
      issue(16'h7FFF, 16'h0001, 1'b0, 1'b1);
      issue(16'h8000, 16'h8000, 1'b0, 1'b1);
      drain();

      bp_mode = 1;
      issue(16'h1111, 16'h2222, 1'b1, 1'b1);
      for (int i = 0; i < 40 && !bus.out_valid; i++) @(negedge clk);
      chk("bp_valid", W'(bus.out_valid), W'(1));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 2) begin
            bus.in_a     = 16'hAAAA;
            bus.in_b     = 16'h5555;
            bus.in_cin   = 1'b1;
            bus.in_valid = 1'b1;
         end
         #1;
         chk("bp_in_ready", W'(bus.in_ready), W'(0));
         chk("bp_busy", W'(bus.busy), W'(1));
         if (i == 3) bus.in_valid = 1'b0;
      end
      bp_mode = 0;
      drain();
      repeat (2) @(negedge clk);
      chk("bp_not_taken", W'(bus.busy), W'(0));
      issue(16'h0F0F, 16'h00F1, 1'b0, 1'b1);
      drain();

      issue(16'h1234, 16'h4321, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("arst_in_ready", W'(bus.in_ready), W'(1));
      chk("arst_out_valid", W'(bus.out_valid), W'(0));
      chk("arst_busy", W'(bus.busy), W'(0));
      chk("arst_sum", bus.out_sum, W'(0));
      chk("arst_cout", W'(bus.out_cout), W'(0));
      chk("arst_ovf", W'(bus.out_ovf), W'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      issue(16'h0001, 16'h0002, 1'b0, 1'b1);
      drain();

      bp_mode = 2;
      for (int i = 0; i < 40; i++) begin
         issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      bp_mode = 0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/chunked_add_sequencer.md
# chunked_add_sequencer

Multi-cycle wide adder that sequences a single 4-bit Kogge-Stone prefix-adder slice over a WIDTH-bit operand pair, least-significant nibble first. Each cycle one nibble goes through the slice, and the slice's carry-out is registered as the next nibble's carry-in. It sits between an operand producer and a result consumer, each with a valid/ready handshake. Area is traded for latency: one slice instead of a WIDTH-bit prefix tree.

## Interface
Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
- NCHUNK, WIDTH/4, derived number of nibbles; not overridden.

Ports:
- clk  input  1  rising-edge clock; the single clock domain.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair and carry-in are present.
- in_ready  output  1  block can accept an operation.
- in_a  input  WIDTH  addend A.
- in_b  input  WIDTH  addend B.
- in_cin  input  1  carry-in to bit 0.
- out_valid  output  1  result is present.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  WIDTH  A+B+cin, modulo 2^WIDTH.
- out_cout  output  1  carry out of bit WIDTH-1.
- out_ovf  output  1  two's-complement overflow.
- busy  output  1  high in RUN or DONE.

## Operation
- State machine:
  - IDLE:
    - in_ready=1.
    - On in_valid: latch in_a, in_b and in_cin; clear out_sum; set the chunk index to 0; go to RUN.
  - RUN, one cycle per chunk k:
    - Slice inputs are a[4k+3:4k], b[4k+3:4k], and the carry register.
    - At the clock edge, write the slice sum to out_sum[4k+3:4k] and the slice cout to the carry register.
    - At k=NCHUNK-1, go to DONE.
  - DONE:
    - out_valid=1.
    - out_cout = the carry register.
    - out_ovf = (a[W-1]==b[W-1]) && (out_sum[W-1]!=a[W-1]).
    - On out_ready, go to IDLE.
- in_ready is 1 only in IDLE, so an in_valid in RUN or DONE is ignored and not latched. in_ready has no combinational dependence on out_ready.
- out_sum, out_cout and out_ovf hold stable for as long as out_valid=1.
- The carry register is loaded from in_cin at acceptance. Carry from every chunk propagates, including the all-ones ripple.
- Reset (asserted at any time, including mid-RUN):
  - State goes to IDLE; the operation in flight is discarded.
  - in_ready=1; out_valid, busy, out_sum, out_cout, out_ovf and the carry register are all 0.

## Timing
- Acceptance edge: in_valid && in_ready at rising edge T.
- RUN covers edges T+1 … T+NCHUNK; out_valid rises after edge T+NCHUNK.
- Minimum issue interval is NCHUNK+2 cycles: NCHUNK RUN cycles, 1 DONE cycle, and 1 IDLE cycle.
- Zero-wait case: with out_ready held high, out_valid is high for exactly one cycle.
- Backpressure: DONE is held indefinitely while out_ready=0.
- Critical path: the slice plus one 4-bit write-enable mux. The slice is purely combinational.

## Structure
- Shared adder package holds:
  - the state enum (IDLE/RUN/DONE);
  - the constant CHUNK_W=4;
  - a function computing NCHUNK from WIDTH.
- Sub-module: adder4_ks, the 4-bit Kogge-Stone slice.
  - Ports: a[3:0], b[3:0], cin, sum[3:0], cout.
  - Instantiated once.
- Chunk index width is $clog2(NCHUNK) with a minimum of 1.
- Chunk selection uses indexed part-select; no shift of the operand registers is required.

## Test plan
- Reset: assert rst asynchronously mid-cycle → all outputs 0, in_ready=1 without a clock edge. Release → IDLE.
- Basic add, WIDTH=16: A=0x00FF, B=0x0001, cin=0 → out_sum=0x0100, cout=0, ovf=0. out_valid rises exactly 4 cycles after the acceptance edge.
- Full ripple: A=0xFFFF, B=0x0000, cin=1 → out_sum=0x0000, cout=1, ovf=0.
- Signed overflow cases:
  - A=0x7FFF, B=0x0001, cin=0 → out_sum=0x8000, cout=0, ovf=1.
  - A=0x8000, B=0x8000 → out_sum=0x0000, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, pulse in_valid with new operands during that time → result stable, in_ready=0, new operands not taken. Raise out_ready → IDLE, then the next op is accepted and computed correctly.
- Reset mid-RUN: assert rst during chunk 2 of A=0x1234, B=0x4321 → no out_valid. After release, issue A=0x0001, B=0x0002 → out_sum=0x0003; no stale carry or nibbles remain.
